dma_sched: RTL and testbench
============================

// Module: dma_sched
// PURPOSE
//  Schedules on-chip DMA requesters (video refresh, UART, etc.) onto the xr16 CPU's single DMA slot.
//  - Round-robin arbitration between requesters; the winner holds the grant for a BURST-transfer burst.
//  - Per transfer: issues a one-cycle dma_req (and optionally zerodma) to the control unit.
//  - Waits for the CPU to finish the DMA memory cycle, then acks the requester.
//  - Sits between the peripherals and the CPU control unit's dma_req/zerodma/dma/rdy pins.
// PARAMETERS
//  NREQ   4   number of requesters (2..8)
//  BURST  4   DMA transfers per grant (1..15)
//  TMO    63  max clk cycles in WAIT before abort (1..255)
// PORTS
//  clk       in   1     global clock, rising edge
//  rst_n     in   1     reset: asynchronous, active-low
//  req       in   NREQ  level request per requester; sampled in IDLE only
//  zero_req  in   NREQ  pulse: next burst of requester i restarts the DMA address at 0
//  rdy       in   1     CPU memory access ready (same signal as the control unit's rdy)
//  dma       in   1     CPU control: current memory access is a DMA transfer
//  dma_req   out  1     one-cycle pulse to CPU control: request one DMA transfer
//  zerodma   out  1     one-cycle pulse, coincident with dma_req: zero the DMA address first
//  gnt       out  NREQ  one-hot grant, held from ISSUE of the first transfer to the end of the burst
//  ack       out  NREQ  one-cycle pulse on gnt bit when a transfer completes
//  last      out  1     one-cycle pulse with the ack of the final transfer of a burst
//  busy      out  1     state != IDLE
//  err       out  1     one-cycle pulse on timeout abort
// BEHAVIOUR
//  Reset values: all outputs 0; state=IDLE; rr_ptr=0; zpend=0; cnt=0; tmo_cnt=0. Reset mid-burst aborts silently, with no ack and no err.
//  States (3-bit): IDLE, ISSUE, WAIT, DONE.
//   IDLE: if |req, pick winner w = first set bit of req at or after rr_ptr, cyclic.
//         Register gnt=1<<w, cnt=BURST-1, go ISSUE. If req==0, stay.
//   ISSUE (1 cycle): dma_req=1; zerodma=zpend[w]; clear zpend[w]; tmo_cnt=0; go WAIT.
//   WAIT: transfer complete when dma&rdy (the CPU DMA cycle retires).
//         - On completion: ack[w]=1.
//             cnt==0: last=1, go DONE.
//             otherwise: cnt-=1, go ISSUE.
//         - Otherwise tmo_cnt+=1; at tmo_cnt==TMO: err=1, gnt=0, go IDLE, rr_ptr=w+1 mod NREQ.
//   DONE (1 cycle): gnt=0; rr_ptr=(w+1) mod NREQ; go IDLE.
//  Latency and throughput:
//   - req high in IDLE -> dma_req is asserted 1 cycle later.
//   - Minimum spacing between dma_req pulses is 2 cycles (ISSUE, WAIT-complete).
//   - A BURST-transfer burst takes at least 2*BURST+1 cycles, IDLE to IDLE.
//  zero_req: sets zpend[i] in any state. A zero_req on the granted requester during WAIT is held for
//   the next burst and does not affect the current one. A set and a clear of zpend[i] in the same
//   cycle: set wins.
//  req dropped mid-burst: the burst still completes all BURST transfers (requester must tolerate).
//  rdy low: freezes nothing in this block except the completion test. tmo_cnt counts all clk cycles.
//  dma_req is never asserted while the previous transfer is outstanding (only from ISSUE).
//  Arithmetic: cnt 4-bit unsigned, tmo_cnt 8-bit unsigned, rr_ptr $clog2(NREQ) bits with explicit
//   wrap at NREQ (non-power-of-2 NREQ must work).
// STRUCTURE
//  Package xr16_dma_pkg: state encodings (ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE), width constants
//   CNT_W=4 and TMO_W=8.
//  Sub-module rr_pick: combinational round-robin one-hot picker (in: req, ptr; out: one-hot sel, idx).
//  Top level: state FSM, counters, zpend register, and output registers. All outputs are registered.
// TESTING
//  1 NREQ=4, BURST=4: req=0001, CPU returns dma&rdy 1 cycle after each dma_req
//    -> 4 dma_req pulses; ack[0] x4; last on the 4th; gnt=0001 for 9 cycles.
//  2 req=1111 held, rr_ptr=0 -> grant order 0,1,2,3,0; each burst is 4 acks; no starvation.
//  3 zero_req[2] pulse in IDLE, then req=0100 -> zerodma only with the first dma_req of that burst.
//    The next burst has zerodma=0.
//  4 TMO=63, CPU never asserts dma -> err pulses 64 cycles after ISSUE; gnt=0; next winner is w+1.
//  5 rdy low for 10 cycles during WAIT with dma=1 -> no ack until rdy=1; then completion is normal.
//  6 rst_n low mid-burst (cnt=2) -> all outputs 0 immediately, no ack/err.
//    After release, req=0010 restarts a full 4-transfer burst from rr_ptr=0.

Source files
------------

// File: rtl/xr16_dma_pkg.sv
// xr16 DMA scheduler shared definitions.
// FSM state encodings, counter widths and a cyclic distance helper.
package xr16_dma_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;

  localparam int CNT_W = 4;
  localparam int TMO_W = 8;

  // steps from p forward to j, wrapping at n
  function automatic int rr_dist(int j, int p, int n);
    return (j >= p) ? (j - p) : (j - p + n);
  endfunction

endpackage

// File: rtl/dma_sched_rr_pick.sv
// Round-robin one-hot picker for the DMA scheduler.
// Selects the first set request at or after ptr, wrapping at NREQ.
module rr_pick
  import xr16_dma_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  sel,
  output logic [PTR_W-1:0] idx
);

  // keep the requester with the smallest cyclic distance from ptr
  always_comb begin : p_pick
    int best;
    int d;
    best = NREQ;
    d    = 0;
    sel  = '0;
    idx  = '0;
    for (int j = 0; j < NREQ; j++) begin
      d = rr_dist(j, int'(ptr), NREQ);
      if (req[j] && d < best) begin
        best   = d;
        sel    = '0;
        sel[j] = 1'b1;
        idx    = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/dma_sched.sv
// xr16 DMA slot scheduler: round-robin grant, BURST transfers per grant,
// one dma_req per transfer, ack on dma&rdy retire, abort after TMO cycles.
module dma_sched
  import xr16_dma_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int BURST = 4,
  parameter int TMO   = 63
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] zero_req,
  input  logic            rdy,
  input  logic            dma,
  output logic            dma_req,
  output logic            zerodma,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] ack,
  output logic            last,
  output logic            busy,
  output logic            err
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [TMO_W-1:0] r_tmo;
  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] r_widx;
  logic [NREQ-1:0]  r_zpend;
  logic             r_dma_req;
  logic             r_zerodma;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_ack;
  logic             r_last;
  logic             r_busy;
  logic             r_err;

  logic [NREQ-1:0]  w_sel;
  logic [PTR_W-1:0] w_idx;
  logic [NREQ-1:0]  w_zclr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic             w_done;
  logic             w_tmo_hit;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req (req),
    .ptr (r_rr_ptr),
    .sel (w_sel),
    .idx (w_idx)
  );

  assign w_done    = dma & rdy;
  assign w_tmo_hit = (r_tmo == TMO_W'(TMO - 1));
  assign w_ptr_nxt = (r_widx == PTR_W'(NREQ - 1))
                   ? '0 : r_widx + 1'b1;
  // zero request is consumed only when a burst is granted
  assign w_zclr    = (r_state == ST_IDLE) ? w_sel : '0;

  // sticky zero-address requests; a new request beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zpend <= '0;
    end else begin
      r_zpend <= (r_zpend & ~w_zclr) | zero_req;
    end
  end

  // burst FSM with registered pulse and grant outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_tmo     <= '0;
      r_rr_ptr  <= '0;
      r_widx    <= '0;
      r_dma_req <= 1'b0;
      r_zerodma <= 1'b0;
      r_gnt     <= '0;
      r_ack     <= '0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_dma_req <= 1'b0;
      r_zerodma <= 1'b0;
      r_ack     <= '0;
      r_last    <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_gnt     <= w_sel;
            r_widx    <= w_idx;
            r_cnt     <= CNT_W'(BURST - 1);
            r_dma_req <= 1'b1;
            r_zerodma <= |(r_zpend & w_sel);
            r_busy    <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_tmo   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_done) begin
            r_ack <= r_gnt;
            if (r_cnt == '0) begin
              r_last  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_cnt     <= r_cnt - 1'b1;
              r_dma_req <= 1'b1;
              r_state   <= ST_ISSUE;
            end
          end else if (w_tmo_hit) begin
            r_err    <= 1'b1;
            r_gnt    <= '0;
            r_busy   <= 1'b0;
            r_rr_ptr <= w_ptr_nxt;
            r_state  <= ST_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        ST_DONE: begin
          r_gnt    <= '0;
          r_busy   <= 1'b0;
          r_rr_ptr <= w_ptr_nxt;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign dma_req = r_dma_req;
  assign zerodma = r_zerodma;
  assign gnt     = r_gnt;
  assign ack     = r_ack;
  assign last    = r_last;
  assign busy    = r_busy;
  assign err     = r_err;

endmodule

// File: tb/tb_dma_sched.sv
// Testbench for dma_sched: directed trace table, corner sequences,
// and randomized traffic checked against a burst-level reference model.
module tb_dma_sched;

  localparam int NREQ  = 4;
  localparam int BURST = 4;
  localparam int TMO   = 63;
  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] zero_req = '0;
  logic       rdy = 1'b0;
  logic       dma = 1'b0;
  logic       dma_req, zerodma, last, busy, err;
  logic [3:0] gnt, ack;

  int n_vec = 0;
  int n_err = 0;

  dma_sched #(.NREQ(NREQ), .BURST(BURST), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .zero_req(zero_req),
    .rdy(rdy), .dma(dma), .dma_req(dma_req), .zerodma(zerodma),
    .gnt(gnt), .ack(ack), .last(last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // reference model: owner index (-1 = none), transfers done, wait age
  int         m_owner, m_ptr, m_done, m_wait;
  bit         m_close;
  bit [3:0]   m_zp;
  logic [3:0] e_gnt, e_ack;
  logic       e_dreq, e_zd, e_last, e_busy, e_err;

  function automatic void m_reset();
    m_owner = -1; m_ptr = 0; m_done = 0; m_wait = 0;
    m_close = 0; m_zp = '0;
    e_gnt = '0; e_ack = '0; e_dreq = 0; e_zd = 0;
    e_last = 0; e_busy = 0; e_err = 0;
  endfunction

  function automatic void m_step(logic [3:0] rq, logic [3:0] zr,
                                 logic d, logic r);
    bit [3:0] clr, tmp;
    bit       issued;
    int       j;
    clr = '0;
    issued = e_dreq;
    e_dreq = 0; e_zd = 0; e_ack = '0; e_last = 0; e_err = 0;
    if (m_owner < 0) begin
      if (rq != 0) begin
        for (int k = 0; k < NREQ; k++) begin
          j = (m_ptr + k) % NREQ;
          tmp = rq >> j;
          if (m_owner < 0 && tmp[0]) m_owner = j;
        end
        m_done = 0;
        m_close = 0;
        e_gnt = 4'b0001 << m_owner;
        e_dreq = 1;
        tmp = m_zp >> m_owner;
        e_zd = tmp[0];
        clr = 4'b0001 << m_owner;
      end
    end else if (m_close) begin
      m_ptr = (m_owner + 1) % NREQ;
      m_owner = -1;
      m_close = 0;
      e_gnt = '0;
    end else if (issued) begin
      m_wait = 0;
    end else if (d && r) begin
      e_ack = e_gnt;
      m_done++;
      if (m_done == BURST) begin
        e_last = 1;
        m_close = 1;
      end else begin
        e_dreq = 1;
      end
    end else begin
      m_wait++;
      if (m_wait == TMO) begin
        e_err = 1;
        e_gnt = '0;
        m_ptr = (m_owner + 1) % NREQ;
        m_owner = -1;
      end
    end
    m_zp = (m_zp & ~clr) | zr;
    e_busy = (m_owner >= 0);
  endfunction

  function automatic logic [12:0] outs();
    return {dma_req, zerodma, gnt, ack, last, busy, err};
  endfunction

  function automatic logic [12:0] exps();
    return {e_dreq, e_zd, e_gnt, e_ack, e_last, e_busy, e_err};
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
    end
  endtask

  // one clock: advance model on the held inputs, then compare
  task automatic cyc();
    if (rst_n) m_step(req, zero_req, dma, rdy);
    else m_reset();
    @(posedge clk);
    #1;
    chk("model", 32'(outs()), 32'(exps()));
  endtask

  task automatic do_reset();
    rst_n = 0;
    req = '0; zero_req = '0; dma = 0; rdy = 0;
    m_reset();
    #1;
    chk("rst_async", 32'(outs()), 32'd0);
    cyc();
    cyc();
    rst_n = 1;
  endtask

  typedef struct {
    logic [3:0] rq;
    logic       d, r;
    logic       dreq, zd;
    logic [3:0] gnt, ack;
    logic       last, busy, err;
  } vec_t;

  vec_t tv[11];

  initial begin
    int order[$];
    int acks, na, n, ndreq, nstray;
    logic [3:0] prevg;
    logic [7:0] zdv;
    bit pulsed, seen;

    tv[0]  = '{4'b0001, L, L, L, L, 4'b0000, 4'b0000, L, L, L};
    tv[1]  = '{4'b0000, L, L, H, L, 4'b0001, 4'b0000, L, H, L};
    tv[2]  = '{4'b0000, H, H, L, L, 4'b0001, 4'b0000, L, H, L};
    tv[3]  = '{4'b0000, L, L, H, L, 4'b0001, 4'b0001, L, H, L};
    tv[4]  = '{4'b0000, H, H, L, L, 4'b0001, 4'b0000, L, H, L};
    tv[5]  = '{4'b0000, L, L, H, L, 4'b0001, 4'b0001, L, H, L};
    tv[6]  = '{4'b0000, H, H, L, L, 4'b0001, 4'b0000, L, H, L};
    tv[7]  = '{4'b0000, L, L, H, L, 4'b0001, 4'b0001, L, H, L};
    tv[8]  = '{4'b0000, H, H, L, L, 4'b0001, 4'b0000, L, H, L};
    tv[9]  = '{4'b0000, L, L, L, L, 4'b0001, 4'b0001, H, H, L};
    tv[10] = '{4'b0000, L, L, L, L, 4'b0000, 4'b0000, L, L, L};

    // single-requester burst trace
    do_reset();
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("trace%0d", i), 32'(outs()),
          32'({tv[i].dreq, tv[i].zd, tv[i].gnt, tv[i].ack,
               tv[i].last, tv[i].busy, tv[i].err}));
      req = tv[i].rq; dma = tv[i].d; rdy = tv[i].r;
      cyc();
    end

    // all requesting: rotation 0,1,2,3,0 with full bursts
    do_reset();
    req = 4'b1111; dma = 1; rdy = 1;
    acks = 0; prevg = '0;
    for (int c = 0; c < 100 && order.size() < 5; c++) begin
      cyc();
      if (gnt != 0 && prevg == 0) begin
        order.push_back($clog2(gnt));
        acks = 0;
      end
      if (ack != 0) acks++;
      if (last) chk("burst_acks", 32'(acks), 32'd4);
      prevg = gnt;
    end
    chk("rr_count", 32'(order.size()), 32'd5);
    for (int i = 0; i < order.size(); i++)
      chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 4));

    // zero request: first transfer of each burst only, held across WAIT
    do_reset();
    dma = 1; rdy = 1;
    zero_req = 4'b0100;
    cyc();
    zero_req = '0; req = 4'b0100;
    ndreq = 0; nstray = 0; zdv = '0; pulsed = 0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      zero_req = '0;
      if (dma_req) begin
        if (ndreq < 8) zdv[ndreq] = zerodma;
        ndreq++;
      end else if (zerodma) begin
        nstray++;
      end
      if (ndreq == 1 && !dma_req && !pulsed) begin
        zero_req = 4'b0100;
        pulsed = 1;
      end
    end
    req = '0;
    cyc();
    chk("zd_dreq_count", 32'(ndreq), 32'd8);
    chk("zd_pattern", 32'(zdv), 32'h11);
    chk("zd_stray", 32'(nstray), 32'd0);

    // timeout: CPU never takes the slot
    do_reset();
    rdy = 1; req = 4'b0100;
    cyc();
    req = 4'b1111;
    n = 0;
    for (int c = 1; c <= 100; c++) begin
      cyc();
      if (err) begin
        n = c;
        break;
      end
    end
    chk("tmo_cycles", 32'(n), 32'd64);
    chk("tmo_gnt", 32'(gnt), 32'd0);
    cyc();
    chk("tmo_next", 32'(gnt), 32'b1000);

    // rdy low stalls completion only
    do_reset();
    req = 4'b0001;
    cyc();
    req = '0; dma = 1; rdy = 0;
    for (int i = 0; i < 11; i++) begin
      cyc();
      chk("rdy_hold_ack", 32'(ack), 32'd0);
    end
    rdy = 1;
    cyc();
    chk("rdy_release_ack", 32'(ack), 32'b0001);
    na = 1; seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      cyc();
      if (ack == 4'b0001) na++;
      if (last) seen = 1;
    end
    chk("rdy_burst_acks", 32'(na), 32'd4);

    // reset in the middle of a burst
    do_reset();
    req = 4'b0001; dma = 1; rdy = 1;
    cyc();
    req = '0;
    cyc();
    cyc();
    chk("mid_ack_seen", 32'(ack), 32'b0001);
    rst_n = 0;
    m_reset();
    #1;
    chk("mid_rst_async", 32'(outs()), 32'd0);
    cyc();
    cyc();
    rst_n = 1;
    req = 4'b0010;
    cyc();
    req = '0;
    chk("mid_regrant", 32'(gnt), 32'b0010);
    na = 0; seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      cyc();
      if (ack == 4'b0010) na++;
      if (last) seen = 1;
    end
    chk("mid_burst_acks", 32'(na), 32'd4);
    chk("mid_burst_last", 32'(seen), 32'd1);

    // randomized traffic against the model
    do_reset();
    for (int ch = 0; ch < 16; ch++) begin
      int p;
      p = (ch % 4 == 0) ? 2 : (ch % 4 == 1) ? 30 :
          (ch % 4 == 2) ? 70 : 100;
      for (int c = 0; c < 150; c++) begin
        req = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
        zero_req = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0;
        dma = ($urandom_range(0, 99) < 32'(p));
        rdy = ($urandom_range(0, 99) < 85);
        cyc();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
